ysyx_040750_muldiv_unit: RTL

Parametrised iterative multiply/divide execution unit for the EX stage. It implements the RV64M operations, plus the word forms used by MULW/DIVW/DIVUW/REMW/REMUW, with a valid/ready request handshake, a result-hold handshake toward EX/MEM and a pipeline flush. It sits beside the single-cycle GPR ALU; the EX stage stalls on O_req_ready and O_result_valid.

---
 rtl/ysyx_040750_muldiv_unit_if.sv | 28 ++
 rtl/ysyx_040750_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   master : EX side; drives the request, operands, flush and downstream ready
//   slave  : the muldiv unit; drives O_req_ready, O_result, O_result_valid, O_busy
interface ysyx_040750_muldiv_unit_if #(
   parameter int XLEN = 64
);
   logic            I_req_valid;
   logic            O_req_ready;
   logic [XLEN-1:0] I_op1;
   logic [XLEN-1:0] I_op2;
   logic [2:0]      I_funct3;
   logic            I_word_op;
   logic            I_flush;
   logic            I_EX_MEM_ready;
   logic [XLEN-1:0] O_result;
   logic            O_result_valid;
   logic            O_busy;

   modport master (
      output I_req_valid, I_op1, I_op2, I_funct3, I_word_op, I_flush, I_EX_MEM_ready,
      input  O_req_ready, O_result, O_result_valid, O_busy
   );

   modport slave (
      input  I_req_valid, I_op1, I_op2, I_funct3, I_word_op, I_flush, I_EX_MEM_ready,
      output O_req_ready, O_result, O_result_valid, O_busy
   );
endinterface

// File: rtl/ysyx_040750_muldiv_unit.sv
// Iterative RV64M multiply/divide unit (IDLE -> CALC -> DONE).
//   I_sys_clk, I_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : request handshake, operands, funct3/word select,
//                        flush, result-hold handshake toward EX/MEM
// Multiply is shift-add, MUL_STEP multiplier bits per cycle; divide is
// restoring, one quotient bit per cycle. Both work on magnitudes and apply
// the sign on the edge that retires the last iteration.
module ysyx_040750_muldiv_unit #(
   parameter int XLEN      = 64,
   parameter int MUL_STEP  = 1,
   parameter int EARLY_OUT = 1
) (
   input logic                      I_sys_clk,
   input logic                      I_rst_n,
   ysyx_040750_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e            state_q, state_d;
   logic [2*XLEN-1:0] acc_q, acc_d;     // product, or remainder in low bits
   logic [2*XLEN-1:0] sh_q, sh_d;       // shifted multiplicand, or divisor
   logic [XLEN-1:0]   mq_q, mq_d;       // multiplier, or dividend/quotient
   logic [XLEN-1:0]   dvd_q, dvd_d;     // dividend as the architectural result
   logic [XLEN-1:0]   result_q, result_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              word_q, word_d, s1_q, s1_d, s2_q, s2_d, dz_q, dz_d, ov_q, ov_d;

   logic              accept, is_div_in, sg1_in, sg2_in, neg1_in, neg2_in, dz_in, ov_in;
   logic [XLEN-1:0]   x1_in, x2_in, m1_in, m2_in;
   logic [CW-1:0]     n_in;

   // Operand decode, used only on the accept edge
   always_comb begin
      accept    = (state_q == IDLE) && bus.I_req_valid && !bus.I_flush;
      is_div_in = bus.I_funct3[2];
      // word multiplies only need the low 32 bits, so they run unsigned
      sg1_in = is_div_in ? !bus.I_funct3[0]
                         : (!bus.I_word_op && (bus.I_funct3 == 3'b001 || bus.I_funct3 == 3'b010));
      sg2_in = is_div_in ? !bus.I_funct3[0] : (!bus.I_word_op && bus.I_funct3 == 3'b001);
      if (bus.I_word_op) begin
         x1_in = sg1_in ? XLEN'($signed(bus.I_op1[31:0])) : XLEN'(bus.I_op1[31:0]);
         x2_in = sg2_in ? XLEN'($signed(bus.I_op2[31:0])) : XLEN'(bus.I_op2[31:0]);
      end else begin
         x1_in = bus.I_op1;
         x2_in = bus.I_op2;
      end
      neg1_in = sg1_in && x1_in[XLEN-1];
      neg2_in = sg2_in && x2_in[XLEN-1];
      m1_in   = neg1_in ? -x1_in : x1_in;
      m2_in   = neg2_in ? -x2_in : x2_in;
      dz_in   = is_div_in && (x2_in == '0);
      ov_in   = is_div_in && !bus.I_funct3[0] && (x2_in == '1) &&
                (x1_in == (bus.I_word_op ? XLEN'($signed(32'h8000_0000)) : XMIN));
      if (is_div_in)
         n_in = (EARLY_OUT != 0 && (dz_in || ov_in)) ? CW'(1)
                                                    : (bus.I_word_op ? CW'(32) : CW'(XLEN));
      else
         n_in = bus.I_word_op ? CW'(32 / MUL_STEP) : CW'(XLEN / MUL_STEP);
   end

   logic [2*XLEN-1:0] mul_sum, step_acc, step_sh, prod_s;
   logic [XLEN:0]     rem_sh;
   logic [XLEN-1:0]   rem_nx, step_mq, quo_s, rem_s, raw, fin;
   logic              div_ge;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      sh_d     = sh_q;
      mq_d     = mq_q;
      dvd_d    = dvd_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      word_d   = word_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      dz_d     = dz_q;
      ov_d     = ov_q;

      mul_sum = acc_q;
      for (int k = 0; k < MUL_STEP; k++)
         if (mq_q[k]) mul_sum = mul_sum + (sh_q << k);

      rem_sh = {acc_q[XLEN-1:0], mq_q[XLEN-1]};
      div_ge = rem_sh >= {1'b0, sh_q[XLEN-1:0]};
      rem_nx = div_ge ? XLEN'(rem_sh - {1'b0, sh_q[XLEN-1:0]}) : rem_sh[XLEN-1:0];

      if (f3_q[2]) begin
         step_acc = {{XLEN{1'b0}}, rem_nx};
         step_sh  = sh_q;
         step_mq  = {mq_q[XLEN-2:0], div_ge};
      end else begin
         step_acc = mul_sum;
         step_sh  = sh_q << MUL_STEP;
         step_mq  = mq_q >> MUL_STEP;
      end

      // Result as it stands after this iteration; only latched on the last one
      prod_s = (s1_q ^ s2_q) ? -step_acc : step_acc;
      quo_s  = (s1_q ^ s2_q) ? -step_mq : step_mq;
      rem_s  = s1_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
      case (f3_q)
         3'b000:                raw = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: raw = word_q ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:        raw = dz_q ? '1 : (ov_q ? dvd_q : quo_s);
         default:               raw = dz_q ? dvd_q : (ov_q ? '0 : rem_s);
      endcase
      fin = word_q ? XLEN'($signed(raw[31:0])) : raw;

      case (state_q)
         IDLE: if (accept) begin
            state_d = CALC;
            f3_d    = bus.I_funct3;
            word_d  = bus.I_word_op;
            s1_d    = neg1_in;
            s2_d    = neg2_in;
            dz_d    = dz_in;
            ov_d    = ov_in;
            cnt_d   = n_in;
            dvd_d   = bus.I_word_op ? XLEN'($signed(bus.I_op1[31:0])) : bus.I_op1;
            acc_d   = '0;
            if (is_div_in) begin
               sh_d = {{XLEN{1'b0}}, m2_in};
               // word dividends sit at the top so the same MSB-first loop works
               mq_d = bus.I_word_op ? (m1_in << (XLEN - 32)) : m1_in;
            end else begin
               sh_d = {{XLEN{1'b0}}, m1_in};
               mq_d = m2_in;
            end
         end
         CALC: begin
            acc_d = step_acc;
            sh_d  = step_sh;
            mq_d  = step_mq;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               result_d = fin;
            end
         end
         DONE: if (bus.I_EX_MEM_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // flush beats completion, downstream handshake and a same-cycle accept
      if (bus.I_flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         sh_q     <= '0;
         mq_q     <= '0;
         dvd_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         f3_q     <= '0;
         word_q   <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         dz_q     <= 1'b0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         sh_q     <= sh_d;
         mq_q     <= mq_d;
         dvd_q    <= dvd_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         word_q   <= word_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         dz_q     <= dz_d;
         ov_q     <= ov_d;
      end
   end

   assign bus.O_req_ready    = (state_q == IDLE);
   assign bus.O_busy         = (state_q != IDLE);
   assign bus.O_result_valid = (state_q == DONE);
   assign bus.O_result       = result_q;
endmodule
